pe_execute_unit: RTL and testbench

- Two-stage SIMD execute pipeline directly downstream of pe_fetch_unit.
- Consumes pe_opcode, data_a and data_b (4 lanes x DATA_LEN).
- Stage 1 produces lane-wise ADD/SUB/MUL results, or the lane products for DOTP.
- Stage 2 reduces those products to a scalar dot product.
- Results and valid pulses go back to pe_fetch_unit for STORE_TEMP_S1/S2 and STORE_RESULT.

---
 rtl/pe_pkg.sv | 21 ++
 rtl/pe_lane_alu.sv | 64 ++++++
 rtl/pe_execute_unit.sv | 116 +++++++++++
 tb/tb_pe_execute_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// pe_pkg: shared definitions for the PE fetch/execute pipeline.
//   DATA_LEN  - lane width in bits
//   LANES     - number of SIMD lanes (the datapath is built for exactly 4)
//   pe_op_t   - 3-bit opcode encoding shared with pe_fetch_unit
//   lane_vec_t- packed lane vector; lane i occupies bits [i*DATA_LEN +: DATA_LEN]
package pe_pkg;

  localparam int DATA_LEN = 32;
  localparam int LANES    = 4;

  typedef enum logic [2:0] {
    PE_NOP  = 3'd0,
    PE_ADD  = 3'd1,
    PE_SUB  = 3'd2,
    PE_MUL  = 3'd3,
    PE_DOTP = 3'd4
  } pe_op_t;

  typedef logic [LANES-1:0][DATA_LEN-1:0] lane_vec_t;

endpackage

// File: rtl/pe_lane_alu.sv
// pe_lane_alu: combinational single-lane arithmetic for the execute stage.
//   op     - decoded opcode (ADD/SUB/MUL/DOTP; anything else yields zeros)
//   a, b   - two's complement lane operands
//   result - wrap-around lane result (low DATA_LEN bits for products)
//   ovf    - signed overflow of this lane's operation
module pe_lane_alu
  import pe_pkg::*;
(
  input  pe_op_t              op,
  input  logic [DATA_LEN-1:0] a,
  input  logic [DATA_LEN-1:0] b,
  output logic [DATA_LEN-1:0] result,
  output logic                ovf
);

  localparam int PW = 2 * DATA_LEN;

  logic [DATA_LEN-1:0] sum_s;
  logic [DATA_LEN-1:0] diff_s;
  logic [PW-1:0]       a_ext_s;
  logic [PW-1:0]       b_ext_s;
  logic [PW-1:0]       prod_s;
  logic                add_ovf_s;
  logic                sub_ovf_s;
  logic                mul_ovf_s;

  assign sum_s   = a + b;
  assign diff_s  = a - b;
  // Sign-extend to full width so the low PW bits of the product are exact.
  assign a_ext_s = {{DATA_LEN{a[DATA_LEN-1]}}, a};
  assign b_ext_s = {{DATA_LEN{b[DATA_LEN-1]}}, b};
  assign prod_s  = a_ext_s * b_ext_s;

  // Overflow when operand signs allow it and the result sign flips.
  assign add_ovf_s = (a[DATA_LEN-1] == b[DATA_LEN-1]) && (sum_s[DATA_LEN-1]  != a[DATA_LEN-1]);
  assign sub_ovf_s = (a[DATA_LEN-1] != b[DATA_LEN-1]) && (diff_s[DATA_LEN-1] != a[DATA_LEN-1]);
  // Product fits only if every bit above the truncation point repeats its sign bit.
  assign mul_ovf_s = (prod_s[PW-1:DATA_LEN-1] != {(DATA_LEN+1){prod_s[DATA_LEN-1]}});

  // Select the lane result and overflow for the current opcode.
  always_comb begin
    result = {DATA_LEN{1'b0}};
    ovf    = 1'b0;
    case (op)
      PE_ADD: begin
        result = sum_s;
        ovf    = add_ovf_s;
      end
      PE_SUB: begin
        result = diff_s;
        ovf    = sub_ovf_s;
      end
      PE_MUL, PE_DOTP: begin
        result = prod_s[DATA_LEN-1:0];
        ovf    = mul_ovf_s;
      end
      default: begin
        result = {DATA_LEN{1'b0}};
        ovf    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pe_execute_unit.sv
// pe_execute_unit: two-stage SIMD execute pipeline behind pe_fetch_unit.
//   clk, rst            - clock and synchronous active-high reset
//   stop                - blocks acceptance of new ops while high
//   pe_opcode           - 0 NOP, 1 ADD, 2 SUB, 3 MUL, 4 DOTP, 5..7 NOP
//   data_a, data_b      - packed 4-lane operands
//   pe_stage_1_output   - lane results (or DOTP lane products), 1-cycle latency
//   pe_stage_1_valid    - one-cycle pulse on each stage-1 update
//   pe_stage_2_output   - DOTP scalar (sum of stage-1 products), 2-cycle latency
//   pe_stage_2_valid    - one-cycle pulse on each stage-2 update
//   pe_overflow         - sticky per-lane signed overflow flags
module pe_execute_unit
  import pe_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stop,
  input  logic [2:0]                pe_opcode,
  input  logic [DATA_LEN*LANES-1:0] data_a,
  input  logic [DATA_LEN*LANES-1:0] data_b,
  output logic [DATA_LEN*LANES-1:0] pe_stage_1_output,
  output logic                      pe_stage_1_valid,
  output logic [DATA_LEN-1:0]       pe_stage_2_output,
  output logic                      pe_stage_2_valid,
  output logic [LANES-1:0]          pe_overflow
);

  pe_op_t              op_s;
  logic                accept_s;
  logic                is_dotp_s;
  lane_vec_t           lane_res_s;
  logic [LANES-1:0]    lane_ovf_s;
  logic [DATA_LEN-1:0] dot_sum_s;

  lane_vec_t           stage1_out_r;
  logic                stage1_valid_r;
  logic [DATA_LEN-1:0] stage2_out_r;
  logic                stage2_valid_r;
  logic                dotp_pending_r;
  logic [LANES-1:0]    overflow_r;

  assign op_s = pe_op_t'(pe_opcode);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pe_lane_alu u_alu (
      .op     (op_s),
      .a      (data_a[i*DATA_LEN +: DATA_LEN]),
      .b      (data_b[i*DATA_LEN +: DATA_LEN]),
      .result (lane_res_s[i]),
      .ovf    (lane_ovf_s[i])
    );
  end

  // Decide whether the presented opcode is taken this cycle.
  always_comb begin
    accept_s  = 1'b0;
    is_dotp_s = 1'b0;
    if (!stop) begin
      case (op_s)
        PE_ADD, PE_SUB, PE_MUL: begin
          accept_s  = 1'b1;
          is_dotp_s = 1'b0;
        end
        PE_DOTP: begin
          accept_s  = 1'b1;
          is_dotp_s = 1'b1;
        end
        default: begin
          accept_s  = 1'b0;
          is_dotp_s = 1'b0;
        end
      endcase
    end else begin
      accept_s  = 1'b0;
      is_dotp_s = 1'b0;
    end
  end

  // Reduce the registered lane products; only consumed when a DOTP is pending,
  // so a following op overwriting stage 1 in the same edge cannot corrupt it.
  always_comb begin
    dot_sum_s = {DATA_LEN{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      dot_sum_s = dot_sum_s + stage1_out_r[i];
    end
  end

  // Stage registers, DOTP-pending flag and sticky overflow flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage1_out_r   <= {(DATA_LEN*LANES){1'b0}};
      stage1_valid_r <= 1'b0;
      stage2_out_r   <= {DATA_LEN{1'b0}};
      stage2_valid_r <= 1'b0;
      dotp_pending_r <= 1'b0;
      overflow_r     <= {LANES{1'b0}};
    end else begin
      stage1_valid_r <= accept_s;
      dotp_pending_r <= is_dotp_s;
      stage2_valid_r <= dotp_pending_r;
      if (accept_s) begin
        stage1_out_r <= lane_res_s;
        overflow_r   <= overflow_r | lane_ovf_s;
      end
      if (dotp_pending_r) begin
        stage2_out_r <= dot_sum_s;
      end
    end
  end

  assign pe_stage_1_output = stage1_out_r;
  assign pe_stage_1_valid  = stage1_valid_r;
  assign pe_stage_2_output = stage2_out_r;
  assign pe_stage_2_valid  = stage2_valid_r;
  assign pe_overflow       = overflow_r;

endmodule

// File: tb/tb_pe_execute_unit.sv
// tb_pe_execute_unit: table-driven bench with a scoreboard for pe_execute_unit.
// Each accepted op pushes its expected stage-1 lanes (and, for DOTP, the
// expected scalar) with the cycle they must appear; outputs are checked every
// cycle #1 after the rising edge, including hold values and sticky overflow.
module tb_pe_execute_unit;
  import pe_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                stop;
  logic [2:0]          pe_opcode;
  lane_vec_t           data_a;
  lane_vec_t           data_b;
  lane_vec_t           s1_out;
  logic                s1_v;
  logic [DATA_LEN-1:0] s2_out;
  logic                s2_v;
  logic [LANES-1:0]    ovf;

  pe_execute_unit dut (
    .clk               (clk),
    .rst               (rst),
    .stop              (stop),
    .pe_opcode         (pe_opcode),
    .data_a            (data_a),
    .data_b            (data_b),
    .pe_stage_1_output (s1_out),
    .pe_stage_1_valid  (s1_v),
    .pe_stage_2_output (s2_out),
    .pe_stage_2_valid  (s2_v),
    .pe_overflow       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       op;
    logic             stop;
    lane_vec_t        a;
    lane_vec_t        b;
    lane_vec_t        exp;
    logic [LANES-1:0] ovf;
  } vec_t;

  typedef struct { int due; lane_vec_t val; } s1_ent_t;
  typedef struct { int due; logic [DATA_LEN-1:0] val; } s2_ent_t;

  s1_ent_t             q1[$];
  s2_ent_t             q2[$];
  int                  cyc;
  int                  checks;
  int                  errors;
  lane_vec_t           s1_exp;
  logic [DATA_LEN-1:0] s2_exp;
  logic [LANES-1:0]    ovf_exp;
  localparam int NV = 14;
  vec_t                tbl [NV];

  function automatic lane_vec_t mk(input logic [31:0] l0, input logic [31:0] l1,
                                   input logic [31:0] l2, input logic [31:0] l3);
    lane_vec_t v;
    v[0] = l0; v[1] = l1; v[2] = l2; v[3] = l3;
    return v;
  endfunction

  task automatic check_outputs();
    s1_ent_t e1;
    s2_ent_t e2;
    logic    exp_v;
    exp_v = (q1.size() != 0) && (q1[0].due == cyc);
    checks++;
    if (s1_v !== exp_v) begin
      errors++;
      $display("FAIL s1_valid cyc=%0d actual=%b required=%b", cyc, s1_v, exp_v);
    end
    if (exp_v) begin
      e1 = q1.pop_front();
      s1_exp = e1.val;
    end
    checks++;
    if (s1_out !== s1_exp) begin
      errors++;
      $display("FAIL s1_data cyc=%0d actual=%h required=%h", cyc, s1_out, s1_exp);
    end
    exp_v = (q2.size() != 0) && (q2[0].due == cyc);
    checks++;
    if (s2_v !== exp_v) begin
      errors++;
      $display("FAIL s2_valid cyc=%0d actual=%b required=%b", cyc, s2_v, exp_v);
    end
    if (exp_v) begin
      e2 = q2.pop_front();
      s2_exp = e2.val;
    end
    checks++;
    if (s2_out !== s2_exp) begin
      errors++;
      $display("FAIL s2_data cyc=%0d actual=%h required=%h", cyc, s2_out, s2_exp);
    end
    checks++;
    if (ovf !== ovf_exp) begin
      errors++;
      $display("FAIL overflow cyc=%0d actual=%b required=%b", cyc, ovf, ovf_exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic [2:0] op,
                      input lane_vec_t a, input lane_vec_t b,
                      input lane_vec_t exp, input logic [LANES-1:0] ovf_after);
    s1_ent_t e1;
    s2_ent_t e2;
    rst = r; stop = s; pe_opcode = op; data_a = a; data_b = b;
    @(posedge clk);
    cyc++;
    if (r) begin
      q1.delete();
      q2.delete();
      s1_exp  = '0;
      s2_exp  = '0;
      ovf_exp = '0;
    end else if (!s && op >= 3'd1 && op <= 3'd4) begin
      e1.due = cyc;
      e1.val = exp;
      q1.push_back(e1);
      if (op == 3'd4) begin
        e2.due = cyc + 1;
        e2.val = exp[0] + exp[1] + exp[2] + exp[3];
        q2.push_back(e2);
      end
      ovf_exp = ovf_after;
    end
    #1;
    check_outputs();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 3'd0, '0, '0, '0, ovf_exp);
  endtask

  lane_vec_t a1, b1, add1, ad, bd, pd;

  initial begin
    cyc = 0; checks = 0; errors = 0;
    s1_exp = '0; s2_exp = '0; ovf_exp = '0;
    a1   = mk(32'd1, 32'd2, 32'd3, 32'd4);
    b1   = mk(32'd10, 32'd20, 32'd30, 32'd40);
    add1 = mk(32'd11, 32'd22, 32'd33, 32'd44);
    ad   = mk(32'd1, 32'd2, 32'd3, 32'd4);
    bd   = mk(32'd5, 32'd6, 32'd7, 32'd8);
    pd   = mk(32'd5, 32'd12, 32'd21, 32'd32);

    tbl[0]  = '{3'd1, 1'b0, a1, b1, add1, 4'b0000};
    tbl[1]  = '{3'd2, 1'b0, a1, b1,
                mk(32'hFFFFFFF7, 32'hFFFFFFEE, 32'hFFFFFFE5, 32'hFFFFFFDC), 4'b0000};
    tbl[2]  = '{3'd3, 1'b0, mk(32'h00010000, 32'd3, 32'hFFFFFFFE, 32'd5),
                mk(32'h00010000, 32'd4, 32'd7, 32'hFFFFFFFF),
                mk(32'd0, 32'd12, 32'hFFFFFFF2, 32'hFFFFFFFB), 4'b0001};
    tbl[3]  = '{3'd1, 1'b0, a1, b1, add1, 4'b0001};
    tbl[4]  = '{3'd1, 1'b1, b1, b1, '0, 4'b0001};
    tbl[5]  = '{3'd7, 1'b0, b1, b1, '0, 4'b0001};
    tbl[6]  = '{3'd0, 1'b0, b1, b1, '0, 4'b0001};
    tbl[7]  = '{3'd4, 1'b0, ad, bd, pd, 4'b0001};
    tbl[8]  = '{3'd1, 1'b0, a1, b1, add1, 4'b0001};
    tbl[9]  = '{3'd4, 1'b0, mk(32'h7FFFFFFF, 32'h7FFFFFFF, 32'd0, 32'd0),
                mk(32'd1, 32'd1, 32'd0, 32'd0),
                mk(32'h7FFFFFFF, 32'h7FFFFFFF, 32'd0, 32'd0), 4'b0001};
    tbl[10] = '{3'd0, 1'b0, '0, '0, '0, 4'b0001};
    tbl[11] = '{3'd1, 1'b0, mk(32'h7FFFFFFF, 32'h80000000, 32'd0, 32'hFFFFFFFF),
                mk(32'd1, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF),
                mk(32'h80000000, 32'h7FFFFFFF, 32'd0, 32'hFFFFFFFE), 4'b0011};
    tbl[12] = '{3'd2, 1'b0, mk(32'd5, 32'd0, 32'h80000000, 32'h7FFFFFFF),
                mk(32'd3, 32'd0, 32'd1, 32'hFFFFFFFF),
                mk(32'd2, 32'd0, 32'h7FFFFFFF, 32'h80000000), 4'b1111};
    tbl[13] = '{3'd0, 1'b0, '0, '0, '0, 4'b1111};

    // Reset, then three quiet cycles.
    step(1'b1, 1'b0, 3'd0, '0, '0, '0, '0);
    for (int i = 0; i < 3; i++) idle();

    for (int i = 0; i < NV; i++) begin
      step(1'b0, tbl[i].stop, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].ovf);
    end
    idle();

    // Reset clears sticky flags and outputs.
    step(1'b1, 1'b0, 3'd0, '0, '0, '0, '0);
    idle();

    // stop raised the cycle after a DOTP is taken: stage 2 still fires.
    step(1'b0, 1'b0, 3'd4, ad, bd, pd, 4'b0000);
    step(1'b0, 1'b1, 3'd1, a1, b1, add1, 4'b0000);
    idle();

    // Reset right after a DOTP is taken: the stage-2 pulse is dropped.
    step(1'b0, 1'b0, 3'd4, ad, bd, pd, 4'b0000);
    step(1'b1, 1'b0, 3'd0, '0, '0, '0, '0);
    idle();
    idle();

    // Reset together with a valid op: reset wins.
    step(1'b1, 1'b0, 3'd1, a1, b1, add1, '0);
    idle();
    idle();

    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d/%0d required=0/0", q1.size(), q2.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
